my_pe_ctrl: RTL and testbench
=============================

# my_pe_ctrl

Sequencer that drives one `my_pe_pv1` processing element through a complete dot-product job. It accepts a single 8-bit input stream with a valid/ready handshake. It first writes N weight bytes into the PE's local RAM (`din`), then streams N activation bytes (`ain`), issuing one PE `valid` per element and waiting for `dvalid` before issuing the next. It sits between the host/DMA byte stream and the PE and returns the final `dout` with a one-cycle `done` pulse.

## Interface
- `L_RAM_SIZE`, default 4: PE RAM address width; max vector length 2**L_RAM_SIZE.
- `TIMEOUT_CYC`, default 255: watchdog limit in cycles; used only with `PE_CTRL_TIMEOUT_EN`.

- `aclk` in 1: single clock, all logic rising-edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle job request, sampled in IDLE only.
- `len` in L_RAM_SIZE+1: vector length N, sampled with `start`; 0 or >2**L_RAM_SIZE means 2**L_RAM_SIZE.
- `sub_mode` in 1: sampled with `start`, held on `pe_subtract` for the whole job.
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in 8: byte stream, first N beats = din, next N = ain.
- `pe_addr` out L_RAM_SIZE, `pe_we` out 1, `pe_din` out 8, `pe_ain` out 8, `pe_valid` out 1, `pe_subtract` out 1: PE controls, all registered.
- `pe_dvalid` in 1, `pe_dout` in 8: PE result handshake.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse at job end.
- `result` out 8: `pe_dout` captured on the last element, held until the next capture.
- `err` out 1: watchdog flag (only with `PE_CTRL_TIMEOUT_EN`, otherwise tied 0).

## Operation
- States: IDLE, LOAD, CALC, WAIT, DONE.
- IDLE: `in_ready`=0. On `start`, latch N and `sub_mode`, clear `cnt`, then go to LOAD.
- LOAD: `in_ready`=1. On each handshake, next cycle `pe_we`=1, `pe_addr`=cnt, `pe_din`=in_data, and `cnt`++. A cycle with no handshake gives `pe_we`=0. After the Nth beat, clear `cnt` and go to CALC.
- CALC: `in_ready`=1. On a handshake, next cycle `pe_valid`=1 (single cycle), `pe_ain`=in_data, `pe_addr`=cnt; then go to WAIT.
- WAIT: `in_ready`=0. On `pe_dvalid`: if cnt==N-1, capture `result`<=`pe_dout` and go to DONE; otherwise `cnt`++ and go back to CALC.
- DONE: `done`=1 for one cycle, then IDLE.
- `pe_dvalid` outside WAIT is ignored. `start` outside IDLE is ignored.
- `cnt` is L_RAM_SIZE+1 bits wide, so N=2**L_RAM_SIZE needs no address wrap. `pe_addr` = cnt[L_RAM_SIZE-1:0].
- Reset values: all outputs 0, `result`=0, state IDLE. An `aresetn` assertion mid-job aborts it immediately and produces no `done`.

## Timing
- Output register stage: PE controls lag the accepting handshake by exactly 1 cycle.
- LOAD with `in_valid` held high takes N cycles, one byte per cycle.
- Each CALC element costs 1 handshake cycle + 1 cycle to reach WAIT + PE latency L until `dvalid` + 1 transition cycle. `in_ready` drops the cycle after the CALC handshake.
- `done` is asserted the cycle after the final `pe_dvalid`; `result` is valid in that same cycle.
- `busy` rises the cycle after `start` and falls the cycle after `done`.

## Configuration
- `PE_CTRL_TIMEOUT_EN` defined: a counter runs in WAIT and clears on entry. If it reaches TIMEOUT_CYC without `pe_dvalid`, then `err`<=1, state goes to IDLE, no `done` is issued, and `result` is unchanged. `err` clears on the next accepted `start`.
- Not defined: no counter; WAIT holds indefinitely; `err` is constant 0.

## Test plan
- Reset: `aresetn`=0 -> every output 0; after release with `start`=0 for 20 cycles -> `busy`=0, `in_ready`=0.
- Full job, N=16 (`len`=0), din=1..16, ain=all 1, `sub_mode`=0, PE model returns sum with L=3 -> 16 `pe_we` pulses at addresses 0..15, 16 `pe_valid` pulses, `result`=0x88, one `done`.
- Backpressure: N=4 with `in_valid` toggling every other cycle -> exactly 4 writes at addresses 0..3 with the correct bytes; no `pe_valid` issued while in WAIT.
- Subtract: `sub_mode`=1, N=2 -> `pe_subtract` high from the first LOAD cycle through `done`, 0 after. A `start` issued mid-job leaves `len`/`sub_mode` unchanged.
- Abort: deassert `aresetn` during WAIT of element 2 -> state IDLE, no `done`; a fresh N=1 job then completes normally.
- With `PE_CTRL_TIMEOUT_EN` and TIMEOUT_CYC=8, PE never returns `dvalid` -> `err`=1 after 8 WAIT cycles, `busy`=0, no `done`; the next `start` clears `err`.

Source files
------------

// File: rtl/my_pe_ctrl.sv
// my_pe_ctrl: sequences one PE through a weight-load then dot-product job from a byte stream.
// Optional watchdog on the PE result handshake is enabled by defining PE_CTRL_TIMEOUT_EN.
module my_pe_ctrl #(
  parameter int L_RAM_SIZE  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [L_RAM_SIZE:0]   len,
  input  logic                  sub_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  output logic [L_RAM_SIZE-1:0] pe_addr,
  output logic                  pe_we,
  output logic [7:0]            pe_din,
  output logic [7:0]            pe_ain,
  output logic                  pe_valid,
  output logic                  pe_subtract,
  input  logic                  pe_dvalid,
  input  logic [7:0]            pe_dout,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            result,
  output logic                  err
);
  localparam int CW = L_RAM_SIZE + 1;
  localparam logic [CW-1:0] MAXN = CW'(1 << L_RAM_SIZE);
  typedef enum logic [2:0] {IDLE, LOAD, CALC, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, n;
  logic hs, last, tmo;
  assign in_ready = (state == LOAD) || (state == CALC);
  assign hs       = in_valid && in_ready;
  assign last     = cnt == n - 1'b1;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
`ifdef PE_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  assign tmo = (state == WAIT) && !pe_dvalid && (tcnt == TW'(TIMEOUT_CYC - 1));
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      tcnt <= (state == WAIT) ? tcnt + 1'b1 : '0;
      if (tmo) err <= 1'b1;
      else if (state == IDLE && start) err <= 1'b0;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (hs && last) state_nx = CALC;
      CALC:    if (hs) state_nx = WAIT;
      WAIT:    if (tmo) state_nx = IDLE;
               else if (pe_dvalid) state_nx = last ? DONE : CALC;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // PE controls are registered, so they trail the accepting handshake by one cycle
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt         <= '0;
      n           <= '0;
      pe_addr     <= '0;
      pe_we       <= 1'b0;
      pe_din      <= '0;
      pe_ain      <= '0;
      pe_valid    <= 1'b0;
      pe_subtract <= 1'b0;
      result      <= '0;
    end else begin
      pe_we    <= (state == LOAD) && hs;
      pe_valid <= (state == CALC) && hs;
      if (hs) begin
        pe_addr <= cnt[L_RAM_SIZE-1:0];
        if (state == LOAD) pe_din <= in_data;
        else pe_ain <= in_data;
      end
      case (state)
        IDLE: if (start) begin
          n           <= (len == '0 || len > MAXN) ? MAXN : len;
          cnt         <= '0;
          pe_subtract <= sub_mode;
        end
        LOAD: if (hs) cnt <= last ? '0 : cnt + 1'b1;
        WAIT: if (tmo) pe_subtract <= 1'b0;
              else if (pe_dvalid) begin
                if (last) result <= pe_dout;
                else cnt <= cnt + 1'b1;
              end
        DONE: pe_subtract <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_my_pe_ctrl.sv
// tb_my_pe_ctrl: randomized scoreboard bench for my_pe_ctrl with a 3-cycle-latency PE model.
module tb_my_pe_ctrl;
  localparam int L = 4;
  logic aclk = 0, aresetn = 0, start = 0, sub_mode = 0, in_valid = 0;
  logic [L:0] len = '0;
  logic [7:0] in_data = '0;
  logic in_ready, pe_we, pe_valid, pe_subtract, busy, done, err, pe_dvalid;
  logic [L-1:0] pe_addr;
  logic [7:0] pe_din, pe_ain, pe_dout, result;
  my_pe_ctrl #(.L_RAM_SIZE(L), .TIMEOUT_CYC(8)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .len(len), .sub_mode(sub_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .pe_addr(pe_addr), .pe_we(pe_we), .pe_din(pe_din), .pe_ain(pe_ain),
    .pe_valid(pe_valid), .pe_subtract(pe_subtract), .pe_dvalid(pe_dvalid),
    .pe_dout(pe_dout), .busy(busy), .done(done), .result(result), .err(err)
  );
  always #5 aclk = ~aclk;

  int total = 0, bad = 0;
  logic [11:0] wq[$], vq[$];
  logic [7:0] rq[$];
  bit job_sub = 0, hang = 0;
  logic [7:0] ram[16];
  logic [7:0] acc = '0;
  logic [2:0] p = '0;

  // PE model: local RAM, multiply-accumulate, dvalid three cycles after valid
  assign pe_dvalid = p[2] && !hang;
  assign pe_dout = acc;
  always @(posedge aclk) begin
    p <= {p[1:0], pe_valid};
    if (start && !busy) acc <= '0;
    if (pe_we) ram[pe_addr] <= pe_din;
    if (pe_valid) acc <= pe_subtract ? acc - ram[pe_addr] * pe_ain : acc + ram[pe_addr] * pe_ain;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge aclk) begin : mon
    if (aresetn) begin
      if (pe_we) begin
        check("we_expected", 32'(wq.size() > 0), 1);
        if (wq.size() > 0) check("write", 32'({pe_addr, pe_din}), 32'(wq.pop_front()));
      end
      if (pe_valid) begin
        check("valid_while_pe_busy", 32'(|p), 0);
        check("valid_expected", 32'(vq.size() > 0), 1);
        if (vq.size() > 0) check("valid", 32'({pe_addr, pe_ain}), 32'(vq.pop_front()));
      end
      if (pe_valid || |p) check("in_ready_in_wait", 32'(in_ready), 0);
      if (done) begin
        check("done_expected", 32'(rq.size() > 0), 1);
        if (rq.size() > 0) check("result", 32'(result), 32'(rq.pop_front()));
      end
      check("pe_subtract", 32'(pe_subtract), busy ? 32'(job_sub) : 0);
    end
  end

  task automatic send(input logic [7:0] b, input bit gap);
    int t;
    if (gap) begin
      in_valid = 0;
      @(negedge aclk);
    end
    in_valid = 1;
    in_data = b;
    t = 0;
    while (!in_ready && t < 500) begin
      @(negedge aclk);
      t++;
    end
    check("handshake_timeout", 32'(t < 500), 1);
    @(negedge aclk);
    in_valid = 0;
  endtask

  function automatic bit pick_gap(input int gm);
    return gm == 1 ? 1'b1 : gm == 2 ? 1'($urandom % 2) : 1'b0;
  endfunction

  task automatic begin_job(input int ln, input bit sub);
    job_sub = sub;
    start = 1;
    len = 5'(ln);
    sub_mode = sub;
    @(negedge aclk);
    start = 0;
    len = 5'($urandom);
    sub_mode = 1'($urandom);
    check("busy_after_start", 32'(busy), 1);
    check("err_after_start", 32'(err), 0);
  endtask

  task automatic do_job(input int ln, input bit sub, input int gm, input bit pat, input bit poke);
    int n, t;
    logic [7:0] w[16], a[16], r;
    n = (ln == 0 || ln > 16) ? 16 : ln;
    r = '0;
    for (int i = 0; i < n; i++) begin
      w[i] = pat ? 8'(i + 1) : 8'($urandom);
      a[i] = pat ? 8'd1 : 8'($urandom);
      wq.push_back({4'(i), w[i]});
      vq.push_back({4'(i), a[i]});
      r = sub ? r - w[i] * a[i] : r + w[i] * a[i];
    end
    rq.push_back(r);
    begin_job(ln, sub);
    for (int i = 0; i < n; i++) begin
      send(w[i], pick_gap(gm));
      if (poke && i == 0) begin
        start = 1;
        len = 5'd3;
        sub_mode = !sub;
        @(negedge aclk);
        start = 0;
      end
    end
    for (int i = 0; i < n; i++) send(a[i], pick_gap(gm));
    t = 0;
    while (rq.size() > 0 && t < 1000) begin
      @(negedge aclk);
      t++;
    end
    check("done_timeout", 32'(rq.size()), 0);
    @(negedge aclk);
    check("busy_after_done", 32'(busy), 0);
    check("writes_left", 32'(wq.size()), 0);
    check("valids_left", 32'(vq.size()), 0);
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_busy"}, 32'(busy), 0);
    check({nm, "_in_ready"}, 32'(in_ready), 0);
    check({nm, "_done"}, 32'(done), 0);
    check({nm, "_pe_we"}, 32'(pe_we), 0);
    check({nm, "_pe_valid"}, 32'(pe_valid), 0);
    check({nm, "_pe_subtract"}, 32'(pe_subtract), 0);
  endtask

  initial begin
    logic [7:0] rsave;
    #1;
    check_idle_outputs("reset");
    check("reset_vals", 32'({pe_addr, pe_din, pe_ain, result, err}), 0);
    repeat (3) @(negedge aclk);
    aresetn = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      check("post_reset_busy", 32'(busy), 0);
      check("post_reset_in_ready", 32'(in_ready), 0);
    end
    do_job(0, 0, 0, 1, 0);
    check("full_result", 32'(result), 32'h88);
    do_job(4, 0, 1, 0, 0);
    do_job(2, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) wq.push_back({4'(i), 8'(i * 3 + 7)});
    for (int i = 0; i < 2; i++) vq.push_back({4'(i), 8'(i + 2)});
    begin_job(4, 1);
    for (int i = 0; i < 4; i++) send(8'(i * 3 + 7), 0);
    for (int i = 0; i < 2; i++) send(8'(i + 2), 0);
    @(negedge aclk);
    check("abort_in_wait", 32'(busy && !in_ready), 1);
    aresetn = 0;
    #1;
    check_idle_outputs("abort");
    check("abort_writes_left", 32'(wq.size()), 0);
    check("abort_valids_left", 32'(vq.size()), 0);
    repeat (3) @(negedge aclk);
    aresetn = 1;
    repeat (10) @(negedge aclk);
    check("abort_idle", 32'(busy), 0);
    do_job(1, 0, 0, 0, 0);
`ifdef PE_CTRL_TIMEOUT_EN
    hang = 1;
    rsave = result;
    wq.push_back({4'd0, 8'h11});
    vq.push_back({4'd0, 8'h22});
    begin_job(1, 1);
    send(8'h11, 0);
    send(8'h22, 0);
    for (int k = 1; k <= 8; k++) begin
      check("err_early", 32'(err), 0);
      @(negedge aclk);
    end
    check("err_set", 32'(err), 1);
    check("timeout_busy", 32'(busy), 0);
    check("timeout_result", 32'(result), 32'(rsave));
    hang = 0;
    repeat (5) @(negedge aclk);
    do_job(1, 0, 0, 0, 0);
`else
    rsave = result;
    check("err_tied", 32'(err), 0);
`endif
    for (int j = 0; j < 8; j++) do_job(int'($urandom_range(0, 31)), 1'($urandom % 2), 2, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
